// File: rtl/apb3_requester_arbiter.sv
// apb3_requester_arbiter
//   Round-robin arbiter plus APB3 requester that shares one APB3 completer
//   among NumRequesters local clients. Each client hands over one read/write
//   command through a valid/ready handshake. The owning client then receives
//   a one-cycle response pulse. Completer wait states are supported, and
//   back-to-back transfers skip the IDLE phase. A non-zero TimeoutCycles
//   abandons a transfer whose completer never raises pready.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   per-client command handshake (req_ready one-hot)
//   req_write             per-client direction, 1 = write
//   req_addr/req_wdata    per-client address / write data, packed by client index
//   rsp_valid             one-hot response pulse to the owning client
//   rsp_rdata/rsp_err     read data (0 for writes/aborts) and timeout flag
//   paddr..pwdata         APB3 requester outputs
//   prdata, pready        APB3 completer inputs
module apb3_requester_arbiter #(
  parameter int NumRequesters = 2,
  parameter int AddressWidth  = 8,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NumRequesters-1:0]              req_valid,
  output logic [NumRequesters-1:0]              req_ready,
  input  logic [NumRequesters-1:0]              req_write,
  input  logic [NumRequesters*AddressWidth-1:0] req_addr,
  input  logic [NumRequesters*DataWidth-1:0]    req_wdata,
  output logic [NumRequesters-1:0]              rsp_valid,
  output logic [DataWidth-1:0]                  rsp_rdata,
  output logic                                  rsp_err,
  output logic [AddressWidth-1:0]               paddr,
  output logic                                  pwrite,
  output logic                                  psel,
  output logic                                  penable,
  output logic [DataWidth-1:0]                  pwdata,
  input  logic [DataWidth-1:0]                  prdata,
  input  logic                                  pready
);

  localparam int IdxWidth = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
  localparam int CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } state_e;

  state_e                state_r;
  state_e                state_next_s;
  logic [IdxWidth-1:0]   last_grant_r;
  logic [IdxWidth-1:0]   owner_r;
  logic [IdxWidth-1:0]   winner_s;
  logic [IdxWidth-1:0]   cand_s;
  logic                  any_valid_s;
  logic                  timeout_s;
  logic                  done_s;
  logic                  grant_point_s;
  logic                  grant_s;
  logic [CntWidth-1:0]   tcnt_r;

  // Client index 'step' positions after 'base', wrapping modulo NumRequesters.
  function automatic logic [IdxWidth-1:0] rr_index(input logic [IdxWidth-1:0] base,
                                                   input int unsigned step);
    int unsigned sum_v;
    sum_v = 32'(base) + step;
    return IdxWidth'(sum_v % 32'(NumRequesters));
  endfunction

  // The counter has already counted TimeoutCycles-1 stalled cycles. So this is
  // the last ACCESS cycle allowed. pready in this same cycle still wins.
  assign timeout_s     = (TimeoutCycles > 0) && (state_r == StAccess) && !pready &&
                         (tcnt_r == CntWidth'(TimeoutCycles - 1));
  assign done_s        = (state_r == StAccess) && (pready || timeout_s);
  assign grant_point_s = (state_r == StIdle) || done_s;
  assign grant_s       = grant_point_s && any_valid_s;

  // Round-robin search: first pending client after the last granted one.
  always_comb begin
    winner_s    = last_grant_r;
    any_valid_s = 1'b0;
    cand_s      = last_grant_r;
    for (int k = 1; k <= NumRequesters; k++) begin
      cand_s = rr_index(last_grant_r, k);
      if (!any_valid_s && req_valid[cand_s]) begin
        any_valid_s = 1'b1;
        winner_s    = cand_s;
      end else begin
        any_valid_s = any_valid_s;
      end
    end
  end

  // Acceptance strobe: only at a grant point, only to the winner.
  always_comb begin
    req_ready = {NumRequesters{1'b0}};
    if (grant_s) begin
      req_ready[winner_s] = 1'b1;
    end else begin
      req_ready = {NumRequesters{1'b0}};
    end
  end

  // Next APB phase. A grant always restarts at SETUP, which gives back-to-back transfers.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      StIdle:   state_next_s = any_valid_s ? StSetup : StIdle;
      StSetup:  state_next_s = StAccess;
      StAccess: begin
        if (done_s) begin
          state_next_s = any_valid_s ? StSetup : StIdle;
        end else begin
          state_next_s = StAccess;
        end
      end
      default:  state_next_s = StIdle;
    endcase
  end

  // Phase register, APB outputs, arbitration pointer, timeout counter and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= StIdle;
      psel         <= 1'b0;
      penable      <= 1'b0;
      paddr        <= {AddressWidth{1'b0}};
      pwrite       <= 1'b0;
      pwdata       <= {DataWidth{1'b0}};
      last_grant_r <= IdxWidth'(NumRequesters - 1);
      owner_r      <= {IdxWidth{1'b0}};
      tcnt_r       <= {CntWidth{1'b0}};
      rsp_valid    <= {NumRequesters{1'b0}};
      rsp_rdata    <= {DataWidth{1'b0}};
      rsp_err      <= 1'b0;
    end else begin
      state_r <= state_next_s;
      psel    <= (state_next_s != StIdle);
      penable <= (state_next_s == StAccess);

      if (grant_s) begin
        paddr        <= req_addr[winner_s*AddressWidth +: AddressWidth];
        pwrite       <= req_write[winner_s];
        pwdata       <= req_wdata[winner_s*DataWidth +: DataWidth];
        last_grant_r <= winner_s;
        owner_r      <= winner_s;
      end else begin
        paddr        <= paddr;
        pwrite       <= pwrite;
        pwdata       <= pwdata;
        last_grant_r <= last_grant_r;
        owner_r      <= owner_r;
      end

      // Count stalled ACCESS cycles. The count clears as soon as ACCESS is left.
      if ((state_r == StAccess) && !done_s) begin
        tcnt_r <= tcnt_r + 1'b1;
      end else begin
        tcnt_r <= {CntWidth{1'b0}};
      end

      rsp_valid <= {NumRequesters{1'b0}};
      rsp_rdata <= {DataWidth{1'b0}};
      rsp_err   <= 1'b0;
      if (done_s) begin
        rsp_valid[owner_r] <= 1'b1;
        rsp_err            <= !pready;
        rsp_rdata          <= (pready && !pwrite) ? prdata : {DataWidth{1'b0}};
      end else begin
        rsp_err            <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb3_requester_arbiter.sv
// Self-checking bench for apb3_requester_arbiter (2 clients, timeout of 4 cycles).
// The reference describes each transfer as a timeline counted from its grant:
// grant, one SETUP cycle, then ACCESS cycles until the completer's chosen wait
// count or the timeout. The expected response comes from a reference memory.
module tb_apb3_requester_arbiter;

  localparam int N  = 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   cv, cw;
  logic [AW-1:0]  ca [N];
  logic [DW-1:0]  cd [N];
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [DW-1:0]  rsp_rdata, pwdata, prdata, junk;
  logic           rsp_err, pwrite, psel, penable, pready_d;
  logic [AW-1:0]  paddr;
  logic [DW-1:0]  mem [256];
  logic [DW-1:0]  ref_mem [256];

  int vectors = 0;
  int miscompares = 0;

  // reference transfer timeline
  int             m_ptr, m_pos, m_owner, m_wait, fixed_wait, mode;
  logic [AW-1:0]  m_addr;
  logic           m_write;
  logic [DW-1:0]  m_wdata;
  logic [N-1:0]   exp_rsp_valid;
  logic           exp_rsp_err;
  logic [DW-1:0]  exp_rsp_rdata;
  int             dut_grants[$];
  int             left_cmds [N];
  int             setup_cnt, psel_hi, rises;
  logic           psel_prev;

  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = ca[IW'(i)];
      req_wdata[i*DW +: DW] = cd[IW'(i)];
    end
  end

  assign prdata = (psel && penable && pready_d) ? mem[paddr] : junk;

  apb3_requester_arbiter #(
    .NumRequesters(N), .AddressWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(cv), .req_ready(req_ready), .req_write(cw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready_d)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_ptr = N - 1; m_owner = 0; m_wait = 0;
    m_addr = '0; m_write = 1'b0; m_wdata = '0;
    exp_rsp_valid = '0; exp_rsp_err = 1'b0; exp_rsp_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cv = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_cmd(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cv[IW'(i)] = 1'b1; cw[IW'(i)] = w; ca[IW'(i)] = a; cd[IW'(i)] = d;
  endtask

  // Client behaviour for the current cycle: 1 = fixed contention burst, 2 = random.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (mode == 1) begin
        if (!cv[IW'(i)] && left_cmds[i] > 0) begin
          set_cmd(i, (i == 1), AW'(8'h30 + i), $urandom());
          left_cmds[i]--;
        end
      end else if (mode == 2) begin
        if (!cv[IW'(i)]) begin
          if ($urandom_range(0, 9) < 4)
            set_cmd(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom());
        end else if ($urandom_range(0, 19) == 0) begin
          cv[IW'(i)] = 1'b0;
        end
      end
    end
  endtask

  // One clock cycle. The task starts at a negedge with the registered outputs settled.
  task automatic cycle();
    int acc_i, win;
    logic gp, any, tmo, done;
    logic [N-1:0] exp_ready, t;
    chk("psel",    64'(psel),    64'(m_pos > 0));
    chk("penable", 64'(penable), 64'(m_pos >= 2));
    chk("paddr",   64'(paddr),   64'(m_addr));
    chk("pwrite",  64'(pwrite),  64'(m_write));
    chk("pwdata",  64'(pwdata),  64'(m_wdata));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp_valid));
    if (exp_rsp_valid != '0) begin
      chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rsp_rdata));
      chk("rsp_err",   64'(rsp_err),   64'(exp_rsp_err));
    end
    acc_i = m_pos - 2;
    if (m_pos >= 2) pready_d = (acc_i == m_wait);
    else            pready_d = 1'($urandom_range(0, 1));
    junk = $urandom();
    #1;
    // completer memory write at the completing ACCESS cycle
    if (psel && penable && pready_d && pwrite) mem[paddr] = pwdata;
    for (int i = 0; i < N; i++) if (req_ready[IW'(i)]) dut_grants.push_back(i);

    tmo  = (m_pos >= 2) && !pready_d && (acc_i == TO - 1);
    done = (m_pos >= 2) && (pready_d || tmo);
    gp   = (m_pos == 0) || done;
    any  = 1'b0;
    win  = 0;
    for (int k = 1; k <= N; k++) begin
      t = cv >> ((m_ptr + k) % N);
      if (!any && t[0]) begin any = 1'b1; win = (m_ptr + k) % N; end
    end
    exp_ready = (gp && any) ? (N'(1) << win) : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));

    exp_rsp_valid = '0; exp_rsp_err = 1'b0; exp_rsp_rdata = '0;
    if (done) begin
      exp_rsp_valid = N'(1) << m_owner;
      exp_rsp_err   = tmo;
      if (!tmo && !m_write) exp_rsp_rdata = ref_mem[m_addr];
      if (!tmo && m_write)  ref_mem[m_addr] = m_wdata;
    end
    if (gp && any) begin
      m_pos = 1; m_owner = win; m_ptr = win;
      m_addr = ca[IW'(win)]; m_write = cw[IW'(win)]; m_wdata = cd[IW'(win)];
      m_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 5));
    end else if (gp) begin
      m_pos = 0;
    end else begin
      m_pos++;
    end
    @(posedge clk);
    #1;
    if (gp && any) cv[IW'(win)] = 1'b0;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      drive();
      if (psel && !penable) setup_cnt++;
      if (psel) psel_hi++;
      if (psel && !psel_prev) rises++;
      psel_prev = psel;
      cycle();
    end
  endtask

  initial begin
    cv = '0; cw = '0; pready_d = 1'b0; junk = '0;
    mode = 0; fixed_wait = 0; psel_prev = 1'b0;
    setup_cnt = 0; psel_hi = 0; rises = 0;
    for (int i = 0; i < N; i++) begin ca[IW'(i)] = '0; cd[IW'(i)] = '0; left_cmds[i] = 0; end
    for (int a = 0; a < 256; a++) begin
      mem[a] = 32'hA5A5_0000 ^ (a * 32'h0101_0101);
      ref_mem[a] = mem[a];
    end
    mem[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
    do_reset();
    chk("reset_psel", 64'(psel), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_paddr", 64'(paddr), 64'(0));

    // single read, zero wait states
    set_cmd(0, 1'b0, 8'h10, 32'h0);
    run(1);
    chk("rd_setup_psel", 64'(psel), 64'(1));
    chk("rd_setup_penable", 64'(penable), 64'(0));
    run(1);
    chk("rd_access_penable", 64'(penable), 64'(1));
    run(1);
    chk("rd_rsp_valid", 64'(rsp_valid), 64'(2'b01));
    chk("rd_rsp_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
    chk("rd_rsp_err", 64'(rsp_err), 64'(0));

    // write then read with two wait states
    fixed_wait = 2;
    set_cmd(1, 1'b1, 8'h20, 32'h5A5A5A5A);
    run(4);
    chk("ws_access_held", 64'(penable), 64'(1));
    chk("ws_no_early_rsp", 64'(rsp_valid), 64'(0));
    run(1);
    chk("ws_wr_rsp_valid", 64'(rsp_valid), 64'(2'b10));
    chk("ws_wr_rsp_rdata", 64'(rsp_rdata), 64'(0));
    set_cmd(1, 1'b0, 8'h20, 32'h0);
    run(5);
    chk("ws_rd_rsp_valid", 64'(rsp_valid), 64'(2'b10));
    chk("ws_rd_rsp_rdata", 64'(rsp_rdata), 64'(32'h5A5A5A5A));

    // contention: 4 commands each, zero wait states
    do_reset();
    fixed_wait = 0; mode = 1; left_cmds[0] = 4; left_cmds[1] = 4;
    dut_grants.delete(); psel_hi = 0; rises = 0; psel_prev = 1'b0;
    run(24);
    mode = 0;
    chk("cont_grant_count", 64'(dut_grants.size()), 64'(8));
    for (int g = 0; g < 8; g++)
      chk("cont_grant_order", 64'((g < dut_grants.size()) ? dut_grants[g] : 99), 64'(g % 2));
    chk("cont_psel_cycles", 64'(psel_hi), 64'(16));
    chk("cont_psel_rises", 64'(rises), 64'(1));

    // timeout: completer never ready
    fixed_wait = 100; psel_hi = 0;
    set_cmd(0, 1'b0, 8'h40, 32'h0);
    run(6);
    chk("to_psel_cycles", 64'(psel_hi), 64'(5));
    chk("to_rsp_valid", 64'(rsp_valid), 64'(2'b01));
    chk("to_rsp_err", 64'(rsp_err), 64'(1));
    chk("to_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("to_idle_psel", 64'(psel), 64'(0));
    run(2);

    // reset during ACCESS for client 1
    set_cmd(1, 1'b1, 8'h50, 32'h1234_5678);
    run(3);
    chk("rm_in_access", 64'(penable), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_async_psel", 64'(psel), 64'(0));
    chk("rm_async_penable", 64'(penable), 64'(0));
    do_reset();
    run(3);
    chk("rm_no_rsp", 64'(rsp_valid), 64'(0));
    fixed_wait = 0;
    dut_grants.delete();
    set_cmd(0, 1'b0, 8'h10, 32'h0);
    set_cmd(1, 1'b0, 8'h20, 32'h0);
    run(1);
    chk("rm_first_grant", 64'((dut_grants.size() > 0) ? dut_grants[0] : 99), 64'(0));
    run(8);

    // withdrawn request during ACCESS
    fixed_wait = 3; dut_grants.delete(); setup_cnt = 0;
    set_cmd(1, 1'b0, 8'h20, 32'h0);
    run(3);
    set_cmd(0, 1'b0, 8'h10, 32'h0);
    run(1);
    cv[0] = 1'b0;
    run(6);
    chk("wd_grant_count", 64'(dut_grants.size()), 64'(1));
    chk("wd_grant_owner", 64'((dut_grants.size() > 0) ? dut_grants[0] : 99), 64'(1));
    chk("wd_setup_count", 64'(setup_cnt), 64'(1));

    // randomized traffic with random waits, including timeouts
    fixed_wait = -1; mode = 2;
    run(3000);
    mode = 0; cv = '0;
    run(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb3_requester_arbiter.md
Name: apb3_requester_arbiter

Overview:
- Round-robin arbiter and APB3 requester that shares one APB3 completer (e.g. the APB3 memory model) among NumRequesters local clients.
- Each client issues single read/write commands over a valid/ready interface and receives a one-cycle response pulse.
- Sequences APB3 IDLE/SETUP/ACCESS phases, supports back-to-back transfers and completer wait states.
- Optional timeout aborts transfers to a hung completer.

Parameters:
- NumRequesters, 2, number of client ports (>=1).
- AddressWidth, 8, APB paddr width.
- DataWidth, 32, APB data width.
- TimeoutCycles, 16, max ACCESS cycles before abort; 0 disables the timeout.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NumRequesters  client i has a command pending
- req_ready  output  NumRequesters  one-hot; client i command accepted this cycle
- req_write  input  NumRequesters  1=write, 0=read, per client
- req_addr  input  NumRequesters*AddressWidth  client i address at [i*AddressWidth +: AddressWidth]
- req_wdata  input  NumRequesters*DataWidth  client i write data at [i*DataWidth +: DataWidth]
- rsp_valid  output  NumRequesters  one-hot, one-cycle response pulse to the owning client
- rsp_rdata  output  DataWidth  read data, shared, valid with rsp_valid
- rsp_err  output  1  1 = transfer aborted by timeout, valid with rsp_valid
- paddr  output  AddressWidth  APB address
- pwrite  output  1  APB direction
- psel  output  1  APB select
- penable  output  1  APB enable
- pwdata  output  DataWidth  APB write data
- prdata  input  DataWidth  APB read data
- pready  input  1  APB ready

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0; state IDLE; timeout counter 0.
  - last_grant = NumRequesters-1, so requester 0 has first priority.
- FSM states: IDLE, SETUP, ACCESS.
- Grant point = state IDLE, or state ACCESS with pready=1 (or timeout).
- At a grant point with any req_valid:
  - Winner = first asserted req_valid searching from last_grant+1 upward, wrapping modulo NumRequesters.
  - req_ready[winner]=1 combinationally in that cycle.
  - Winner's addr/write/wdata registered into paddr/pwrite/pwdata.
  - last_grant and owner updated; next state SETUP.
- A grant point with no req_valid sends the FSM to IDLE.
- req_ready is never asserted outside a grant point. A client may deassert req_valid before acceptance with no effect.
- SETUP: psel=1, penable=0; unconditionally -> ACCESS.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held stable.
  - pready=0: stay; timeout counter increments.
  - pready=1: next cycle rsp_valid[owner]=1 for exactly one cycle, rsp_err=0.
    - rsp_rdata = prdata sampled on that edge for reads, 0 for writes.
- Timeout (TimeoutCycles>0): if counter reaches TimeoutCycles in ACCESS without pready:
  - Transfer is abandoned; next cycle rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0.
  - Counter clears on leaving ACCESS.
- Back-to-back: a grant at the pready cycle goes ACCESS -> SETUP directly.
  - psel stays 1, penable drops to 0 for that SETUP cycle.
- Leaving ACCESS without a new grant: psel=0, penable=0. paddr/pwrite/pwdata hold their last values.
- A pready seen outside ACCESS is ignored.
- Fairness: a continuously requesting client waits at most NumRequesters-1 transfers.
- Reset mid-transfer: psel/penable drop immediately (async). The in-flight transfer gets no response; arbitration restarts from requester 0.
- NumRequesters=1: grant is always client 0.

Test Plan:
- Single read, completer with 0 wait states:
  - Stimulus: client 0 read addr 0x10 (mem=0xDEADBEEF), accepted cycle T.
  - Required: SETUP at T+1, ACCESS at T+2, rsp_valid[0]=1 at T+3 with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Wait states (completer OutputLatency=2):
  - Stimulus: client 1 write 0x5A5A5A5A to 0x20, then read 0x20.
  - Required: write rsp_rdata=0; read returns 0x5A5A5A5A; ACCESS holds 3 cycles; response at T+5.
- Contention:
  - Stimulus: both clients hold valid for 4 commands each.
  - Required: grants alternate 0,1,0,1,...; back-to-back with no IDLE cycle; psel never drops between transfers.
- Timeout:
  - Stimulus: TimeoutCycles=4, pready tied 0.
  - Required: psel high for 1+4 cycles, then rsp_err=1, rsp_rdata=0, FSM back to IDLE.
- Reset mid-transfer:
  - Stimulus: assert rst_n=0 during ACCESS for client 1.
  - Required: psel=0 asynchronously, no rsp_valid pulse; after release, client 0 wins a simultaneous request.
- Withdrawn request:
  - Stimulus: client 0 pulses req_valid one cycle while the FSM is in ACCESS serving client 1.
  - Required: client 0 is never granted; no extra APB transfer.
